// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizes for the FIFO stream reader and its output buffer.
package fifo_stream_reader_pkg;

  localparam int BufferDepth = 2;
  localparam int CountWidth  = 32;

  typedef logic [1:0] occupancy_t;
  typedef logic       ptr_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered output buffer with 1-bit head/tail pointers.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int EntrySize = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [EntrySize-1:0] push_data,
  input  logic                 pop,
  output logic [EntrySize-1:0] head_data,
  output occupancy_t           occupancy
);

  logic [EntrySize-1:0] mem_q [BufferDepth];
  ptr_t                 head_q;
  ptr_t                 tail_q;
  occupancy_t           occ_q;

  // Entries are reset too so the stream output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < BufferDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_data;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      occ_q <= occ_q + occupancy_t'(push) - occupancy_t'(pop);
    end
  end

  assign head_data = mem_q[head_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-port master presenting words as a valid/ready stream.
// Optional delivered-word counter port words_o under FIFO_READER_COUNT_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int EntrySize = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  output logic                  fifo_read_req_o,
  input  logic                  fifo_read_valid_i,
  input  logic [EntrySize-1:0]  fifo_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [EntrySize-1:0]  m_data_o
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CountWidth-1:0] words_o
`endif
);

  occupancy_t stored_q;
  logic       inflight_q;
  logic       pop;
  logic       accept;
  logic [2:0] credit;

  assign pop    = m_valid_o & m_ready_i;
  // A pop only happens with stored_q >= 1, so credit never underflows.
  assign credit = {1'b0, stored_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_read_req_o = enable_i & fifo_read_valid_i & (credit < 3'd2);
  assign accept          = fifo_read_req_o & fifo_read_valid_i;

  // Stage boundary: accepted read -> FIFO data arrives next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept;
    end
  end

  // Stage boundary: returning FIFO data -> buffered stream output
  stream_skid_buf #(
    .EntrySize (EntrySize)
  ) u_buf (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (inflight_q),
    .push_data (fifo_data_i),
    .pop       (pop),
    .head_data (m_data_o),
    .occupancy (stored_q)
  );

  assign m_valid_o = (stored_q != '0);

`ifdef FIFO_READER_COUNT_EN
  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign words_o = count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard of delivered words.
module tb_fifo_stream_reader;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic          fifo_read_req_o;
  logic          fifo_read_valid_i;
  logic [EW-1:0] fifo_data_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [EW-1:0] m_data_o;
`ifdef FIFO_READER_COUNT_EN
  logic [31:0]   words_o;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.EntrySize(EW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .enable_i          (enable_i),
    .fifo_read_req_o   (fifo_read_req_o),
    .fifo_read_valid_i (fifo_read_valid_i),
    .fifo_data_i       (fifo_data_i),
    .m_valid_o         (m_valid_o),
    .m_ready_i         (m_ready_i),
    .m_data_o          (m_data_o)
`ifdef FIFO_READER_COUNT_EN
    ,
    .words_o           (words_o)
`endif
  );

  // Behavioural FIFO: array plus read/write indices, registered read data.
  logic [EW-1:0] fmem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            reads  = 0;
  logic          ovr_en = 1'b0;
  logic          ovr_val = 1'b0;

  assign fifo_read_valid_i = ovr_en ? ovr_val : (wr_ptr != rd_ptr);

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr      <= 0;
      fifo_data_i <= '0;
    end else if (fifo_read_req_o && fifo_read_valid_i) begin
      fifo_data_i <= fmem[rd_ptr % 1024];
      rd_ptr      <= rd_ptr + 1;
      reads       <= reads + 1;
    end
  end

  // Monitor: handshakes sampled mid-cycle, stamped with a negedge cycle count.
  logic [EW-1:0] got[$];
  int            got_t[$];
  int            acc_t[$];
  int            cyc = 0;
  int            inv_err = 0;

  always @(negedge clk) begin
    if (rst_ni) begin
      cyc = cyc + 1;
      if (m_valid_o && m_ready_i) begin
        got.push_back(m_data_o);
        got_t.push_back(cyc);
      end
      if (fifo_read_req_o && fifo_read_valid_i) acc_t.push_back(cyc);
      if (32'(dut.stored_q) + 32'(dut.inflight_q) > 2) inv_err = inv_err + 1;
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  int            gbase = 0;
  int            ebase = 0;
  int            abase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [EW-1:0] w);
    fmem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rst_ni = 1'b0;
    wr_ptr = 0;
    enable_i = 1'b0;
    m_ready_i = 1'b0;
    repeat (2) drive_edge();
    rst_ni = 1'b1;
    gbase = got.size();
    ebase = exp_q.size();
    abase = acc_t.size();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int b;
    b = budget;
    while ((got.size() - gbase) < n && b > 0) begin
      @(negedge clk);
      b = b - 1;
    end
    if ((got.size() - gbase) < n) check({name, "_timeout"}, got.size() - gbase, n);
  endtask

  task automatic compare_all(input string name, input int n);
    for (int i = 0; i < n; i++) check(name, got[gbase + i], exp_q[ebase + i]);
  endtask

  typedef struct {
    logic en;
    logic vld;
    logic rdy;
    logic exp_req;
    logic exp_valid;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic          stable;
    int            r0;
    int            pushed;
    int            budget;
    logic [EW-1:0] w;

    tbl[0] = '{en: 1'b0, vld: 1'b0, rdy: 1'b0, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[1] = '{en: 1'b0, vld: 1'b1, rdy: 1'b0, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[2] = '{en: 1'b1, vld: 1'b0, rdy: 1'b0, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[3] = '{en: 1'b1, vld: 1'b1, rdy: 1'b0, exp_req: 1'b1, exp_valid: 1'b0};
    tbl[4] = '{en: 1'b0, vld: 1'b0, rdy: 1'b1, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[5] = '{en: 1'b0, vld: 1'b1, rdy: 1'b1, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[6] = '{en: 1'b1, vld: 1'b0, rdy: 1'b1, exp_req: 1'b0, exp_valid: 1'b0};
    tbl[7] = '{en: 1'b1, vld: 1'b1, rdy: 1'b1, exp_req: 1'b1, exp_valid: 1'b0};

    // Reset state
    #2;
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_req", fifo_read_req_o, 0);
`ifdef FIFO_READER_COUNT_EN
    check("rst_words", words_o, 0);
`endif
    repeat (2) drive_edge();
    rst_ni = 1'b1;

    // Idle-state request logic, one vector per row
    for (int i = 0; i < 8; i++) begin
      drive_edge();
      ovr_en = 1'b1;
      ovr_val = tbl[i].vld;
      enable_i = tbl[i].en;
      m_ready_i = tbl[i].rdy;
      #1;
      check($sformatf("tbl_req%0d", i), fifo_read_req_o, tbl[i].exp_req);
      check($sformatf("tbl_valid%0d", i), m_valid_o, tbl[i].exp_valid);
      enable_i = 1'b0;
      ovr_en = 1'b0;
    end

    // Preload, consumer always ready: latency and back-to-back delivery
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    m_ready_i = 1'b1;
    enable_i = 1'b1;
    wait_words(4, 50, "burst");
    if ((got.size() - gbase) >= 4 && (acc_t.size() - abase) >= 1) begin
      check("burst_latency", got_t[gbase] - acc_t[abase], 2);
      for (int i = 1; i < 4; i++) check("burst_back2back", got_t[gbase + i] - got_t[gbase], i);
      check("burst_w0", got[gbase], 8'h11);
      check("burst_w1", got[gbase + 1], 8'h22);
      check("burst_w2", got[gbase + 2], 8'h33);
      check("burst_w3", got[gbase + 3], 8'h44);
    end

    // Consumer stalled: only two reads, head word held stable
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    r0 = reads;
    enable_i = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_valid_o && m_data_o != 8'h11) stable = 1'b0;
    end
    check("stall_reads", reads - r0, 2);
    check("stall_valid", m_valid_o, 1);
    check("stall_stable", stable, 1);
    drive_edge();
    m_ready_i = 1'b1;
    wait_words(4, 50, "stall");
    if ((got.size() - gbase) >= 4) compare_all("stall_order", 4);

    // Reset in the middle of a stalled stream with words left in the FIFO
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'hC0 + i));
    enable_i = 1'b1;
    repeat (4) drive_edge();
    rst_ni = 1'b0;
    wr_ptr = 0;
    #1;
    check("midrst_valid", m_valid_o, 0);
    check("midrst_data", m_data_o, 0);
    check("midrst_req", fifo_read_req_o, 0);
    repeat (2) drive_edge();
    rst_ni = 1'b1;
    gbase = got.size();
    ebase = exp_q.size();
    m_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_stale", got.size() - gbase, 0);
    check("midrst_valid_after", m_valid_o, 0);
    push_word(8'h5A); push_word(8'hA5);
    wait_words(2, 30, "midrst");
    if ((got.size() - gbase) >= 2) compare_all("midrst_new", 2);

    // Random ready against a trickle-fed FIFO
    do_reset();
    enable_i = 1'b1;
    pushed = 0;
    budget = 3000;
    while (((got.size() - gbase) < 200) && budget > 0) begin
      drive_edge();
      m_ready_i = $urandom_range(0, 1) != 0;
      if (pushed < 200 && $urandom_range(0, 2) != 0) begin
        w = 8'($urandom_range(0, 255));
        push_word(w);
        pushed = pushed + 1;
      end
      budget = budget - 1;
    end
    check("rand_count", got.size() - gbase, 200);
    if ((got.size() - gbase) >= 200) compare_all("rand_word", 200);
    repeat (5) @(negedge clk);
    check("rand_no_dup", got.size() - gbase, 200);

    // enable_i dropped on the edge that accepts a read
    do_reset();
    push_word(8'hA0); push_word(8'hA1); push_word(8'hA2);
    m_ready_i = 1'b1;
    enable_i = 1'b1;
    budget = 20;
    @(negedge clk);
    while (!(fifo_read_req_o && fifo_read_valid_i) && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    check("endrop_req_seen", fifo_read_req_o && fifo_read_valid_i, 1);
    r0 = reads;
    drive_edge();
    enable_i = 1'b0;
    repeat (8) @(negedge clk);
    check("endrop_reads", reads - r0, 1);
    check("endrop_delivered", got.size() - gbase, 1);
    if ((got.size() - gbase) >= 1) check("endrop_word", got[gbase], 8'hA0);
    drive_edge();
    enable_i = 1'b1;
    wait_words(3, 30, "endrop");
    if ((got.size() - gbase) >= 3) compare_all("endrop_resume", 3);

`ifdef FIFO_READER_COUNT_EN
    // Delivered-word counter and its wrap
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(i + 1));
    m_ready_i = 1'b1;
    enable_i = 1'b1;
    wait_words(5, 30, "count");
    @(negedge clk);
    check("count_five", words_o, 5);
    drive_edge();
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    check("count_forced", words_o, 32'hFFFF_FFFF);
    push_word(8'h77);
    wait_words(6, 30, "count_wrap");
    @(negedge clk);
    check("count_wrap", words_o, 0);
`endif

    check("invariant", inv_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
